// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with direct-select and round-robin
// modes, feeding a single registered output word.
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_next;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  hi_idx;
  logic [SELW-1:0]  lo_idx;
  logic             grant_ok;
  logic             hi_ok;
  logic             lo_ok;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  assign load_en = ~out_valid | out_ready;

  // Round-robin search split in two: lowest valid channel at or above ptr,
  // else lowest valid channel below ptr. The downward loop leaves the lowest hit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hi_idx = '0;
    hi_ok  = 1'b0;
    lo_idx = '0;
    lo_ok  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        if (SELW'(i) >= ptr) begin
          hi_idx = SELW'(i);
          hi_ok  = 1'b1;
        end else begin
          lo_idx = SELW'(i);
          lo_ok  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    if (mode) begin
      grant_ok = hi_ok | lo_ok;
      grant    = hi_ok ? hi_idx : lo_idx;
    end else begin
      // An out-of-range sel matches no channel and simply never grants.
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant    = sel;
          grant_ok = 1'b1;
        end
      end
    end
  end

  assign xfer = ~reset & load_en & grant_ok;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = xfer;
      end
    end
  end

  // Wrap at N, not at 2^SELW, so non-power-of-two channel counts rotate correctly.
  assign ptr_next = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant;
      if (mode) begin
        ptr <= ptr_next;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
